mat_ops_stream: RTL and testbench

//  Parametrised successor of the matrix-op unit. Performs add, subtract, scalar multiply,

---
 rtl/mat_ops_stream_if.sv | 41 ++++
 rtl/mat_ops_stream.sv | 240 ++++++++++++++++++++++++
 tb/tb_mat_ops_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_ops_stream_if.sv
// Interface bundling the command inputs, result stream and status flags of mat_ops_stream.
// The master side issues operations and consumes the stream; the slave side is the engine.
interface mat_ops_stream_if #(
    parameter int DW      = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3
);
    logic                            start_op;
    logic [2:0]                      op_sel;
    logic [MAX_DIM*MAX_DIM*DW-1:0]   matrix_a_flat;
    logic [MAX_DIM*MAX_DIM*DW-1:0]   matrix_b_flat;
    logic [DIM_W-1:0]                dim_a_m;
    logic [DIM_W-1:0]                dim_a_n;
    logic [DIM_W-1:0]                dim_b_m;
    logic [DIM_W-1:0]                dim_b_n;
    logic [DW-1:0]                   scalar_k;
    logic                            out_valid;
    logic                            out_ready;
    logic [DW-1:0]                   out_data;
    logic                            out_last;
    logic [DIM_W-1:0]                result_m;
    logic [DIM_W-1:0]                result_n;
    logic                            busy_flag;
    logic                            op_done;
    logic                            error_flag;
    logic                            overflow_flag;

    modport master (
        output start_op, op_sel, matrix_a_flat, matrix_b_flat,
               dim_a_m, dim_a_n, dim_b_m, dim_b_n, scalar_k, out_ready,
        input  out_valid, out_data, out_last, result_m, result_n,
               busy_flag, op_done, error_flag, overflow_flag
    );

    modport slave (
        input  start_op, op_sel, matrix_a_flat, matrix_b_flat,
               dim_a_m, dim_a_n, dim_b_m, dim_b_n, scalar_k, out_ready,
        output out_valid, out_data, out_last, result_m, result_n,
               busy_flag, op_done, error_flag, overflow_flag
    );
endinterface

// File: rtl/mat_ops_stream.sv
// Streaming matrix engine: add, sub, scalar multiply, transpose and matrix multiply on
// signed matrices up to MAX_DIM x MAX_DIM. One result element per valid/ready beat in
// row-major order, with saturating or wrapping narrowing to DW bits.
module mat_ops_stream #(
    parameter int DW      = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3,
    parameter int ACC_W   = 2*DW+3,
    parameter int SAT_EN  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mat_ops_stream_if.slave bus
);
    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SCAL  = 3'd2;
    localparam logic [2:0] OP_TRANS = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;

    localparam logic [DIM_W-1:0]        DMAX = DIM_W'(MAX_DIM);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 <<< (DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ERR, S_CALC, S_EMIT, S_DONE
    } state_t;

    state_t                   r_state;
    logic [2:0]               r_op;
    logic [DIM_W-1:0]         r_am, r_an, r_bm, r_bn;
    logic signed [DW-1:0]     r_scalar;
    logic [DIM_W-1:0]         r_row, r_col, r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DIM_W-1:0]         r_res_m, r_res_n;
    logic                     r_out_valid;
    logic [DW-1:0]            r_out_data;
    logic                     r_out_last;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic                     r_ovf;

    logic signed [DW-1:0]     w_a [NE];
    logic signed [DW-1:0]     w_b [NE];
    logic [IW-1:0]            w_a_idx, w_b_idx;
    logic signed [DW-1:0]     w_a_el, w_b_el;
    logic signed [ACC_W-1:0]  w_full;
    logic                     w_over, w_under;
    logic [DW-1:0]            w_narrow;
    logic                     w_mac_last, w_elem_last;
    logic                     w_a_bad, w_b_bad, w_bad;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [DW-1:0] v);
        return {{(ACC_W-DW){v[DW-1]}}, v};
    endfunction

    genvar gi;
    for (gi = 0; gi < NE; gi++) begin : g_unpack
        assign w_a[gi] = bus.matrix_a_flat[gi*DW +: DW];
        assign w_b[gi] = bus.matrix_b_flat[gi*DW +: DW];
    end

    // Select which A/B elements feed the current result element (or MAC step).
    always_comb begin
        w_a_idx = IW'(int'(r_row) * MAX_DIM + int'(r_col));
        w_b_idx = IW'(int'(r_row) * MAX_DIM + int'(r_col));
        case (r_op)
            OP_TRANS: w_a_idx = IW'(int'(r_col) * MAX_DIM + int'(r_row));
            OP_MUL: begin
                w_a_idx = IW'(int'(r_row) * MAX_DIM + int'(r_k));
                w_b_idx = IW'(int'(r_k) * MAX_DIM + int'(r_col));
            end
            default: ;
        endcase
        w_a_el = w_a[w_a_idx];
        w_b_el = w_b[w_b_idx];
    end

    // Full-precision element value, then range check and narrowing to DW bits.
    always_comb begin
        case (r_op)
            OP_ADD:   w_full = sx(w_a_el) + sx(w_b_el);
            OP_SUB:   w_full = sx(w_a_el) - sx(w_b_el);
            OP_SCAL:  w_full = sx(w_a_el) * sx(r_scalar);
            OP_TRANS: w_full = sx(w_a_el);
            OP_MUL:   w_full = r_acc + sx(w_a_el) * sx(w_b_el);
            default:  w_full = '0;
        endcase
        w_over  = (w_full > MAXV);
        w_under = (w_full < MINV);
        w_narrow = w_full[DW-1:0];
        if (SAT_EN != 0) begin
            if (w_over) begin
                w_narrow = MAXV[DW-1:0];
            end else if (w_under) begin
                w_narrow = MINV[DW-1:0];
            end
        end
        w_mac_last  = (r_op != OP_MUL) || (r_k == r_an - DIM_W'(1));
        w_elem_last = (r_row == r_res_m - DIM_W'(1)) && (r_col == r_res_n - DIM_W'(1));
    end

    // Legality check of the latched operation and dimensions.
    always_comb begin
        w_a_bad = (r_am == '0) || (r_am > DMAX) || (r_an == '0) || (r_an > DMAX);
        w_b_bad = (r_bm == '0) || (r_bm > DMAX) || (r_bn == '0) || (r_bn > DMAX);
        case (r_op)
            OP_ADD, OP_SUB:    w_bad = w_a_bad || w_b_bad || (r_am != r_bm) || (r_an != r_bn);
            OP_SCAL, OP_TRANS: w_bad = w_a_bad;
            OP_MUL:            w_bad = w_a_bad || w_b_bad || (r_an != r_bm);
            default:           w_bad = 1'b1;
        endcase
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_am        <= '0;
            r_an        <= '0;
            r_bm        <= '0;
            r_bn        <= '0;
            r_scalar    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_res_m     <= '0;
            r_res_n     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_op) begin
                        r_op     <= bus.op_sel;
                        r_am     <= bus.dim_a_m;
                        r_an     <= bus.dim_a_n;
                        r_bm     <= bus.dim_b_m;
                        r_bn     <= bus.dim_b_n;
                        r_scalar <= bus.scalar_k;
                        r_err    <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_op == OP_TRANS) begin
                        r_res_m <= r_an;
                        r_res_n <= r_am;
                    end else if (r_op == OP_MUL) begin
                        r_res_m <= r_am;
                        r_res_n <= r_bn;
                    end else begin
                        r_res_m <= r_am;
                        r_res_n <= r_an;
                    end
                    if (w_bad) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end else begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_ERR: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_CALC: begin
                    if (w_mac_last) begin
                        r_out_data  <= w_narrow;
                        r_out_last  <= w_elem_last;
                        r_out_valid <= 1'b1;
                        if (w_over || w_under) begin
                            r_ovf <= 1'b1;
                        end
                        r_state <= S_EMIT;
                    end else begin
                        r_acc <= w_full;
                        r_k   <= r_k + DIM_W'(1);
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            if (r_col == r_res_n - DIM_W'(1)) begin
                                r_col <= '0;
                                r_row <= r_row + DIM_W'(1);
                            end else begin
                                r_col <= r_col + DIM_W'(1);
                            end
                            r_k     <= '0;
                            r_acc   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_last      = r_out_last;
    assign bus.result_m      = r_res_m;
    assign bus.result_n      = r_res_n;
    assign bus.busy_flag     = r_busy;
    assign bus.op_done       = r_done;
    assign bus.error_flag    = r_err;
    assign bus.overflow_flag = r_ovf;
endmodule

// File: tb/tb_mat_ops_stream.sv
// Bench for mat_ops_stream: three engines (8-bit saturating, 8-bit wrapping, 16-bit
// saturating) run the same command stream in lockstep; each vector picks whose data to check.
module tb_mat_ops_stream;
    logic clk;
    logic rstN;

    logic       tStart;
    logic [2:0] tOp;
    int         tAm, tAn, tBm, tBn, tK;
    int         ma [25];
    int         mb [25];
    logic       tReady;

    logic [25*8-1:0]  fa8, fb8;
    logic [25*16-1:0] fa16, fb16;

    int checks;
    int errors;

    mat_ops_stream_if #(.DW(8),  .MAX_DIM(5), .DIM_W(3)) bus8  ();
    mat_ops_stream_if #(.DW(8),  .MAX_DIM(5), .DIM_W(3)) bus8w ();
    mat_ops_stream_if #(.DW(16), .MAX_DIM(5), .DIM_W(3)) bus16 ();

    mat_ops_stream #(.DW(8),  .MAX_DIM(5), .DIM_W(3), .SAT_EN(1)) u_dut8  (.clk(clk), .rst_n(rstN), .bus(bus8));
    mat_ops_stream #(.DW(8),  .MAX_DIM(5), .DIM_W(3), .SAT_EN(0)) u_dut8w (.clk(clk), .rst_n(rstN), .bus(bus8w));
    mat_ops_stream #(.DW(16), .MAX_DIM(5), .DIM_W(3), .SAT_EN(1)) u_dut16 (.clk(clk), .rst_n(rstN), .bus(bus16));

    // Pack the integer matrices into each engine's flat layout.
    always_comb begin
        fa8 = '0;
        fb8 = '0;
        fa16 = '0;
        fb16 = '0;
        for (int i = 0; i < 25; i++) begin
            fa8[i*8 +: 8]    = 8'(ma[i]);
            fb8[i*8 +: 8]    = 8'(mb[i]);
            fa16[i*16 +: 16] = 16'(ma[i]);
            fb16[i*16 +: 16] = 16'(mb[i]);
        end
    end

    assign bus8.start_op = tStart;   assign bus8w.start_op = tStart;   assign bus16.start_op = tStart;
    assign bus8.op_sel = tOp;        assign bus8w.op_sel = tOp;        assign bus16.op_sel = tOp;
    assign bus8.matrix_a_flat = fa8; assign bus8w.matrix_a_flat = fa8; assign bus16.matrix_a_flat = fa16;
    assign bus8.matrix_b_flat = fb8; assign bus8w.matrix_b_flat = fb8; assign bus16.matrix_b_flat = fb16;
    assign bus8.dim_a_m = 3'(tAm);   assign bus8w.dim_a_m = 3'(tAm);   assign bus16.dim_a_m = 3'(tAm);
    assign bus8.dim_a_n = 3'(tAn);   assign bus8w.dim_a_n = 3'(tAn);   assign bus16.dim_a_n = 3'(tAn);
    assign bus8.dim_b_m = 3'(tBm);   assign bus8w.dim_b_m = 3'(tBm);   assign bus16.dim_b_m = 3'(tBm);
    assign bus8.dim_b_n = 3'(tBn);   assign bus8w.dim_b_n = 3'(tBn);   assign bus16.dim_b_n = 3'(tBn);
    assign bus8.scalar_k = 8'(tK);   assign bus8w.scalar_k = 8'(tK);   assign bus16.scalar_k = 16'(tK);
    assign bus8.out_ready = tReady;  assign bus8w.out_ready = tReady;  assign bus16.out_ready = tReady;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [2:0] op;
        int         am, an, bm, bn, k;
        int         a [25];
        int         b [25];
        int         sel;
        bit         randReady;
        int         nexp;
        int         expv [25];
        int         expM, expN;
        int         expOvf;
    } vec_t;

    vec_t vecs [6];

    function automatic int getData(input int sel);
        case (sel)
            0:       return int'($signed(bus8.out_data));
            1:       return int'($signed(bus8w.out_data));
            default: return int'($signed(bus16.out_data));
        endcase
    endfunction

    function automatic int getOvf(input int sel);
        case (sel)
            0:       return int'(bus8.overflow_flag);
            1:       return int'(bus8w.overflow_flag);
            default: return int'(bus16.overflow_flag);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input int am, input int an,
                                 input int bm, input int bn, input int k);
        @(posedge clk);
        #1;
        tOp = op;
        tAm = am;
        tAn = an;
        tBm = bm;
        tBn = bn;
        tK = k;
        tStart = 1'b1;
        @(posedge clk);
        #1;
        tStart = 1'b0;
    endtask

    task automatic runVector(input int idx);
        int  nb;
        int  firstV;
        int  lastBeat;
        int  doneCyc;
        int  got [25];
        int  gotLast [25];
        bit  prevStall;
        int  prevData;
        bit  rdy;
        int  sel;
        string nm;
        nm = vecs[idx].name;
        sel = vecs[idx].sel;
        nb = 0;
        firstV = -1;
        lastBeat = -1;
        doneCyc = -1;
        prevStall = 1'b0;
        prevData = 0;
        for (int i = 0; i < 25; i++) begin
            ma[i] = vecs[idx].a[i];
            mb[i] = vecs[idx].b[i];
            got[i] = -99999;
            gotLast[i] = -1;
        end
        tReady = 1'b1;
        applyStimulus(vecs[idx].op, vecs[idx].am, vecs[idx].an, vecs[idx].bm, vecs[idx].bn, vecs[idx].k);
        for (int c = 1; c <= 400 && doneCyc < 0; c++) begin
            @(negedge clk);
            if (bus8.op_done) begin
                doneCyc = c;
                checkOutput({nm, "_busy_at_done"}, int'(bus8.busy_flag), 0);
            end else begin
                if (prevStall) begin
                    checkOutput({nm, "_hold_valid"}, int'(bus8.out_valid), 1);
                    checkOutput({nm, "_hold_data"}, getData(sel), prevData);
                end
                rdy = vecs[idx].randReady ? 1'($urandom_range(0, 1)) : 1'b1;
                tReady = rdy;
                if (bus8.out_valid) begin
                    if (firstV < 0) firstV = c;
                    if (rdy) begin
                        if (nb < 25) begin
                            got[nb] = getData(sel);
                            gotLast[nb] = int'(bus8.out_last);
                        end
                        nb++;
                        lastBeat = c;
                    end
                    prevStall = !rdy;
                    prevData = getData(sel);
                end else begin
                    prevStall = 1'b0;
                end
            end
        end
        tReady = 1'b1;
        checkOutput({nm, "_done_seen"}, (doneCyc > 0) ? 1 : 0, 1);
        checkOutput({nm, "_beats"}, nb, vecs[idx].nexp);
        for (int i = 0; i < vecs[idx].nexp; i++) begin
            checkOutput($sformatf("%s_data%0d", nm, i), got[i], vecs[idx].expv[i]);
            checkOutput($sformatf("%s_last%0d", nm, i), gotLast[i], (i == vecs[idx].nexp - 1) ? 1 : 0);
        end
        checkOutput({nm, "_first_valid_cycle"}, firstV,
                    2 + ((vecs[idx].op == 3'd4) ? vecs[idx].an : 1));
        checkOutput({nm, "_done_after_last"}, doneCyc, lastBeat + 1);
        checkOutput({nm, "_result_m"}, int'(bus8.result_m), vecs[idx].expM);
        checkOutput({nm, "_result_n"}, int'(bus8.result_n), vecs[idx].expN);
        checkOutput({nm, "_overflow"}, getOvf(sel), vecs[idx].expOvf);
        @(negedge clk);
        checkOutput({nm, "_done_pulse"}, int'(bus8.op_done), 0);
    endtask

    task automatic runError(input string nm, input logic [2:0] op, input int am, input int an,
                            input int bm, input int bn);
        int doneCyc;
        bit sawValid;
        doneCyc = -1;
        sawValid = 1'b0;
        tReady = 1'b1;
        applyStimulus(op, am, an, bm, bn, 1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus8.op_done && doneCyc < 0) doneCyc = c;
            if (bus8.out_valid) sawValid = 1'b1;
        end
        checkOutput({nm, "_done_cycle"}, doneCyc, 2);
        checkOutput({nm, "_error_flag"}, int'(bus8.error_flag), 1);
        checkOutput({nm, "_no_beats"}, int'(sawValid), 0);
        checkOutput({nm, "_busy"}, int'(bus8.busy_flag), 0);
    endtask

    // Fill the vector table, then run reset, table vectors and hand-written corner cases.
    initial begin
        int  doneSeen;
        int  seenValid;
        checks = 0;
        errors = 0;
        rstN = 1'b0;
        tStart = 1'b0;
        tOp = 3'd0;
        tAm = 0; tAn = 0; tBm = 0; tBn = 0; tK = 0;
        tReady = 1'b1;
        for (int i = 0; i < 25; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 25; i++) begin
                vecs[v].a[i] = 0;
                vecs[v].b[i] = 0;
                vecs[v].expv[i] = 0;
            end
            vecs[v].randReady = 1'b0;
            vecs[v].k = 0;
        end

        vecs[0].name = "scal_x2"; vecs[0].op = 3'd2; vecs[0].sel = 0;
        vecs[0].am = 3; vecs[0].an = 3; vecs[0].bm = 3; vecs[0].bn = 3; vecs[0].k = 2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                vecs[0].a[r*5 + c] = r*3 + c + 1;
                vecs[0].expv[r*3 + c] = 2 * (r*3 + c + 1);
            end
        vecs[0].nexp = 9; vecs[0].expM = 3; vecs[0].expN = 3; vecs[0].expOvf = 0;

        vecs[1].name = "mul_2x3x2"; vecs[1].op = 3'd4; vecs[1].sel = 2;
        vecs[1].am = 2; vecs[1].an = 3; vecs[1].bm = 3; vecs[1].bn = 2;
        vecs[1].a[0] = 1; vecs[1].a[1] = 2; vecs[1].a[2] = 3;
        vecs[1].a[5] = 4; vecs[1].a[6] = 5; vecs[1].a[7] = 6;
        vecs[1].b[0] = 7;  vecs[1].b[1] = 8;
        vecs[1].b[5] = 9;  vecs[1].b[6] = 10;
        vecs[1].b[10] = 11; vecs[1].b[11] = 12;
        vecs[1].expv[0] = 58; vecs[1].expv[1] = 64; vecs[1].expv[2] = 139; vecs[1].expv[3] = 154;
        vecs[1].nexp = 4; vecs[1].expM = 2; vecs[1].expN = 2; vecs[1].expOvf = 0;

        vecs[2].name = "add_sat"; vecs[2].op = 3'd0; vecs[2].sel = 0;
        vecs[2].am = 1; vecs[2].an = 1; vecs[2].bm = 1; vecs[2].bn = 1;
        vecs[2].a[0] = 100; vecs[2].b[0] = 100; vecs[2].expv[0] = 127;
        vecs[2].nexp = 1; vecs[2].expM = 1; vecs[2].expN = 1; vecs[2].expOvf = 1;

        vecs[3] = vecs[2];
        vecs[3].name = "add_wrap"; vecs[3].sel = 1; vecs[3].expv[0] = -56;

        vecs[4].name = "sub_sat"; vecs[4].op = 3'd1; vecs[4].sel = 0;
        vecs[4].am = 1; vecs[4].an = 1; vecs[4].bm = 1; vecs[4].bn = 1;
        vecs[4].a[0] = -100; vecs[4].b[0] = 100; vecs[4].expv[0] = -128;
        vecs[4].nexp = 1; vecs[4].expM = 1; vecs[4].expN = 1; vecs[4].expOvf = 1;

        vecs[5].name = "transpose"; vecs[5].op = 3'd3; vecs[5].sel = 0; vecs[5].randReady = 1'b1;
        vecs[5].am = 2; vecs[5].an = 3; vecs[5].bm = 0; vecs[5].bn = 0;
        vecs[5].a[0] = 1; vecs[5].a[1] = 2; vecs[5].a[2] = 3;
        vecs[5].a[5] = 4; vecs[5].a[6] = 5; vecs[5].a[7] = 6;
        vecs[5].expv[0] = 1; vecs[5].expv[1] = 4; vecs[5].expv[2] = 2;
        vecs[5].expv[3] = 5; vecs[5].expv[4] = 3; vecs[5].expv[5] = 6;
        vecs[5].nexp = 6; vecs[5].expM = 3; vecs[5].expN = 2; vecs[5].expOvf = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", int'(bus8.out_valid), 0);
        checkOutput("reset_busy", int'(bus8.busy_flag), 0);
        checkOutput("reset_done", int'(bus8.op_done), 0);
        checkOutput("reset_error", int'(bus8.error_flag), 0);
        checkOutput("reset_overflow", int'(bus8.overflow_flag), 0);
        checkOutput("reset_last", int'(bus8.out_last), 0);
        checkOutput("reset_data", int'(bus8.out_data), 0);
        checkOutput("reset_result_m", int'(bus8.result_m), 0);
        rstN = 1'b1;

        for (int v = 0; v < 6; v++) begin
            runVector(v);
        end

        for (int i = 0; i < 25; i++) begin
            ma[i] = 1;
            mb[i] = 1;
        end
        runError("err_add_dims", 3'd0, 2, 2, 3, 3);
        runError("err_op111", 3'd7, 2, 2, 2, 2);
        runError("err_dim0", 3'd2, 0, 2, 2, 2);

        applyStimulus(3'd2, 1, 1, 1, 1, 3);
        @(negedge clk);
        checkOutput("err_cleared", int'(bus8.error_flag), 0);
        doneSeen = 0;
        for (int c = 0; c < 20 && doneSeen == 0; c++) begin
            @(negedge clk);
            if (bus8.op_done) doneSeen = 1;
        end
        checkOutput("clear_run_done", doneSeen, 1);

        tReady = 1'b0;
        applyStimulus(3'd4, 5, 5, 5, 5, 0);
        seenValid = 0;
        for (int c = 0; c < 50 && seenValid == 0; c++) begin
            @(negedge clk);
            if (bus8.out_valid) seenValid = 1;
        end
        checkOutput("mul5_valid_seen", seenValid, 1);
        checkOutput("mul5_first_data", getData(0), 5);
        tOp = 3'd7;
        tStart = 1'b1;
        @(negedge clk);
        tStart = 1'b0;
        @(negedge clk);
        checkOutput("busy_start_error", int'(bus8.error_flag), 0);
        checkOutput("busy_start_busy", int'(bus8.busy_flag), 1);
        checkOutput("busy_start_valid", int'(bus8.out_valid), 1);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", int'(bus8.out_valid), 0);
        checkOutput("midrst_busy", int'(bus8.busy_flag), 0);
        checkOutput("midrst_done", int'(bus8.op_done), 0);
        rstN = 1'b1;
        tReady = 1'b1;
        doneSeen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus8.op_done || bus8.out_valid) doneSeen = 1;
        end
        checkOutput("midrst_quiet", doneSeen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
